// File: rtl/serv_seq_ctrl.sv
// Bit-serial execution sequencer: fetch handshake, register-file wait, W/B-cycle
// counting run, and the second-stage wait used by two-stage (init) instructions.
module serv_seq_ctrl #(
    parameter int W        = 32,
    parameter int B        = 1,
    parameter int WITH_CSR = 1,
    parameter int MDU      = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_branch_op,
    input  logic                   i_cond_branch,
    input  logic                   i_bne_or_bge,
    input  logic                   i_mem_op,
    input  logic                   i_shift_op,
    input  logic                   i_slt_op,
    input  logic                   i_mdu_op,
    input  logic                   i_e_op,
    input  logic                   i_rd_op,
    input  logic                   i_new_irq,
    input  logic                   i_alu_cmp,
    input  logic                   i_ctrl_misalign,
    input  logic                   i_mem_misalign,
    input  logic                   i_sh_done,
    input  logic                   i_ibus_ack,
    input  logic                   i_dbus_ack,
    input  logic                   i_rf_ready,
    input  logic                   i_mdu_ready,
    output logic [$clog2(W)-1:0]   o_cnt,
    output logic [$clog2(W)-4:0]   o_mem_bytecnt,
    output logic                   o_init,
    output logic                   o_cnt_en,
    output logic                   o_cnt_done,
    output logic                   o_ctrl_pc_en,
    output logic                   o_ctrl_jump,
    output logic                   o_ctrl_trap,
    output logic                   o_ibus_cyc,
    output logic                   o_dbus_cyc,
    output logic                   o_mdu_valid,
    output logic                   o_rf_rreq,
    output logic                   o_rf_wreq,
    output logic                   o_rf_rd_en
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] STEP = CW'(B);
    localparam logic [CW-1:0] LAST = CW'(W - B);

    typedef enum logic [1:0] {FETCH, WAIT_RF, RUN, WAIT2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done_q, cnt_done_d;
    logic          init_done_q, init_done_d;
    logic          jump_q, jump_d;
    logic          trap_q, trap_d;
    logic          w2_first_q, w2_first_d;

    logic csr_en, mdu_en, two_stage, jump_now;
    assign csr_en    = (WITH_CSR != 0);
    assign mdu_en    = (MDU != 0);
    assign two_stage = i_slt_op | i_mem_op | i_branch_op | i_shift_op | (mdu_en & i_mdu_op);
    // An interrupt pending during the run collapses the instruction to one stage.
    assign o_init    = two_stage & ~i_new_irq & ~init_done_q;
    assign jump_now  = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= FETCH;
            cnt_q       <= '0;
            cnt_done_q  <= 1'b0;
            init_done_q <= 1'b0;
            jump_q      <= 1'b0;
            trap_q      <= 1'b0;
            w2_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cnt_done_q  <= cnt_done_d;
            init_done_q <= init_done_d;
            jump_q      <= jump_d;
            trap_q      <= trap_d;
            w2_first_q  <= w2_first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        jump_d      = jump_q;
        trap_d      = trap_q;
        w2_first_d  = 1'b0;
        o_rf_rreq   = 1'b0;
        o_rf_wreq   = 1'b0;
        o_dbus_cyc  = 1'b0;
        o_mdu_valid = 1'b0;
        // Registered so it is high exactly in the cycle where cnt_q == W-B.
        cnt_done_d  = (state_q == RUN) && !cnt_done_q && ((cnt_q + STEP) == LAST);
        unique case (state_q)
            FETCH: begin
                if (i_ibus_ack) begin
                    o_rf_rreq = 1'b1;
                    state_d   = WAIT_RF;
                end
            end
            WAIT_RF: begin
                if (i_rf_ready) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + STEP;
                if (cnt_done_q) begin
                    if (o_init) begin
                        init_done_d = 1'b1;
                        jump_d      = jump_now;
                        trap_d      = csr_en & ((jump_now & i_ctrl_misalign) |
                                                (i_mem_op & i_mem_misalign));
                        w2_first_d  = 1'b1;
                        state_d     = WAIT2;
                    end else begin
                        init_done_d = 1'b0;
                        jump_d      = 1'b0;
                        trap_d      = 1'b0;
                        state_d     = FETCH;
                    end
                end
            end
            WAIT2: begin
                o_dbus_cyc  = i_mem_op & ~i_mem_misalign & ~trap_q;
                o_mdu_valid = mdu_en & i_mdu_op;
                if (trap_q && w2_first_q) begin
                    o_rf_rreq = 1'b1;
                    state_d   = WAIT_RF;
                end else if (((i_slt_op | i_branch_op) && w2_first_q) ||
                             (i_shift_op && i_sh_done) ||
                             (i_mem_op && i_dbus_ack && !trap_q) ||
                             (mdu_en && i_mdu_op && i_mdu_ready)) begin
                    o_rf_wreq = 1'b1;
                    state_d   = WAIT_RF;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign o_cnt         = cnt_q;
    assign o_mem_bytecnt = cnt_q[CW-1:3];
    assign o_cnt_en      = (state_q == RUN);
    assign o_cnt_done    = cnt_done_q;
    assign o_ctrl_pc_en  = o_cnt_en & ~o_init;
    assign o_ctrl_jump   = jump_q;
    assign o_ctrl_trap   = csr_en & (i_e_op | i_new_irq | trap_q);
    assign o_ibus_cyc    = (state_q == FETCH) & i_rst_n;
    assign o_rf_rd_en    = i_rd_op & ~o_init;
endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Directed bench: a W=32/B=1 instance and a W=64/B=4 instance share one stimulus set.
module tb_serv_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic branch_op, cond_branch, bne_or_bge, mem_op, shift_op, slt_op, mdu_op, e_op, rd_op;
    logic new_irq, alu_cmp, ctrl_misalign, mem_misalign, sh_done;
    logic ibus_ack, dbus_ack, rf_ready, mdu_ready;

    logic [4:0] cnt32;  logic [1:0] bc32;
    logic init32, en32, done32, pc32, jump32, trap32, ibus32, dbus32, mdv32, rreq32, wreq32, rd32;
    logic [5:0] cnt64;  logic [2:0] bc64;
    logic init64, en64, done64, pc64, jump64, trap64, ibus64, dbus64, mdv64, rreq64, wreq64, rd64;

    int vecs = 0;
    int errs = 0;

    serv_seq_ctrl #(.W(32), .B(1)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_branch_op(branch_op), .i_cond_branch(cond_branch), .i_bne_or_bge(bne_or_bge),
        .i_mem_op(mem_op), .i_shift_op(shift_op), .i_slt_op(slt_op), .i_mdu_op(mdu_op),
        .i_e_op(e_op), .i_rd_op(rd_op), .i_new_irq(new_irq), .i_alu_cmp(alu_cmp),
        .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign), .i_sh_done(sh_done),
        .i_ibus_ack(ibus_ack), .i_dbus_ack(dbus_ack), .i_rf_ready(rf_ready), .i_mdu_ready(mdu_ready),
        .o_cnt(cnt32), .o_mem_bytecnt(bc32), .o_init(init32), .o_cnt_en(en32),
        .o_cnt_done(done32), .o_ctrl_pc_en(pc32), .o_ctrl_jump(jump32), .o_ctrl_trap(trap32),
        .o_ibus_cyc(ibus32), .o_dbus_cyc(dbus32), .o_mdu_valid(mdv32), .o_rf_rreq(rreq32),
        .o_rf_wreq(wreq32), .o_rf_rd_en(rd32));

    serv_seq_ctrl #(.W(64), .B(4)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_branch_op(branch_op), .i_cond_branch(cond_branch), .i_bne_or_bge(bne_or_bge),
        .i_mem_op(mem_op), .i_shift_op(shift_op), .i_slt_op(slt_op), .i_mdu_op(mdu_op),
        .i_e_op(e_op), .i_rd_op(rd_op), .i_new_irq(new_irq), .i_alu_cmp(alu_cmp),
        .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign), .i_sh_done(sh_done),
        .i_ibus_ack(ibus_ack), .i_dbus_ack(dbus_ack), .i_rf_ready(rf_ready), .i_mdu_ready(mdu_ready),
        .o_cnt(cnt64), .o_mem_bytecnt(bc64), .o_init(init64), .o_cnt_en(en64),
        .o_cnt_done(done64), .o_ctrl_pc_en(pc64), .o_ctrl_jump(jump64), .o_ctrl_trap(trap64),
        .o_ibus_cyc(ibus64), .o_dbus_cyc(dbus64), .o_mdu_valid(mdv64), .o_rf_rreq(rreq64),
        .o_rf_wreq(wreq64), .o_rf_rd_en(rd64));

    // Measurement results of the most recent RUN phase.
    int len, last_cnt, last_bc, done_cnt, done_at, pc_cnt, trap_cnt, step_err;

    task automatic clear_inputs();
        {branch_op, cond_branch, bne_or_bge, mem_op, shift_op, slt_op, mdu_op, e_op, rd_op} = '0;
        {new_irq, alu_cmp, ctrl_misalign, mem_misalign, sh_done} = '0;
        {ibus_ack, dbus_ack, rf_ready, mdu_ready} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // FETCH -> WAIT_RF -> RUN; leaves rf_ready high until the next negedge.
    task automatic fetch();
        @(negedge clk); ibus_ack = 1'b1;
        @(negedge clk); ibus_ack = 1'b0; rf_ready = 1'b1;
    endtask

    // Observe one RUN phase; returns at the first negedge where o_cnt_en is low.
    task automatic measure(input bit w64);
        int c, b, step;
        bit en, dn, pc, tr;
        len = 0; last_cnt = -1; last_bc = -1; done_cnt = 0; done_at = -1;
        pc_cnt = 0; trap_cnt = 0; step_err = 0;
        step = w64 ? 4 : 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rf_ready = 1'b0;
            #1;
            en = w64 ? en64 : en32;
            if (!en) break;
            c  = w64 ? int'(cnt64) : int'(cnt32);
            b  = w64 ? int'(bc64) : int'(bc32);
            dn = w64 ? done64 : done32;
            pc = w64 ? pc64 : pc32;
            tr = w64 ? trap64 : trap32;
            if (c != len * step) step_err++;
            if (dn) begin done_cnt++; done_at = c; end
            if (pc) pc_cnt++;
            if (tr) trap_cnt++;
            last_cnt = c; last_bc = b;
            len++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (ibus32 !== 1'b0) begin errs++; $display("FAIL rst_ibus got %b want 0", ibus32); end
        vecs++;
        if ({cnt32, bc32, init32, en32, done32, pc32, jump32, trap32, dbus32, mdv32, rreq32, wreq32, rd32} !== '0) begin
            errs++; $display("FAIL rst_outputs got cnt=%0d en=%b done=%b jump=%b trap=%b not all zero", cnt32, en32, done32, jump32, trap32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (ibus32 !== 1'b1) begin errs++; $display("FAIL rst_release_ibus got %b want 1", ibus32); end
        // Stray acks in FETCH must not move the FSM.
        @(negedge clk);
        dbus_ack = 1'b1; mdu_ready = 1'b1; sh_done = 1'b1; rf_ready = 1'b1;
        #1;
        vecs++;
        if (wreq32 !== 1'b0) begin errs++; $display("FAIL stray_ack_wreq got %b want 0", wreq32); end
        @(negedge clk);
        clear_inputs();
        #1;
        vecs++;
        if ({en32, ibus32} !== 2'b01) begin errs++; $display("FAIL stray_ack_state got en=%b ibus=%b want en=0 ibus=1", en32, ibus32); end
    endtask

    task automatic test_addi_w32();
        do_reset();
        rd_op = 1'b1;
        @(negedge clk); ibus_ack = 1'b1;
        #1;
        vecs++;
        if (rreq32 !== 1'b1) begin errs++; $display("FAIL addi_rreq got %b want 1", rreq32); end
        @(negedge clk); ibus_ack = 1'b0; rf_ready = 1'b1;
        #1;
        vecs++;
        if (en32 !== 1'b0) begin errs++; $display("FAIL addi_waitrf_en got %b want 0", en32); end
        measure(1'b0);
        vecs++;
        if (len != 32) begin errs++; $display("FAIL addi32_len got %0d want 32", len); end
        vecs++;
        if (step_err != 0) begin errs++; $display("FAIL addi32_cnt_step got %0d bad steps want 0", step_err); end
        vecs++;
        if (done_cnt != 1 || done_at != 31) begin errs++; $display("FAIL addi32_done got %0d pulses at cnt %0d want 1 at 31", done_cnt, done_at); end
        vecs++;
        if (pc_cnt != 32) begin errs++; $display("FAIL addi32_pc_en got %0d want 32", pc_cnt); end
        vecs++;
        if (ibus32 !== 1'b1) begin errs++; $display("FAIL addi32_refetch got %b want 1", ibus32); end
        vecs++;
        if (rd32 !== 1'b1) begin errs++; $display("FAIL addi32_rd_en got %b want 1", rd32); end
    endtask

    task automatic test_addi_w64();
        do_reset();
        rd_op = 1'b1;
        fetch();
        measure(1'b1);
        vecs++;
        if (len != 16) begin errs++; $display("FAIL addi64_len got %0d want 16", len); end
        vecs++;
        if (last_cnt != 60 || last_bc != 7) begin errs++; $display("FAIL addi64_last got cnt=%0d bytecnt=%0d want 60/7", last_cnt, last_bc); end
        vecs++;
        if (step_err != 0) begin errs++; $display("FAIL addi64_cnt_step got %0d bad steps want 0", step_err); end
        vecs++;
        if (done_cnt != 1 || done_at != 60) begin errs++; $display("FAIL addi64_done got %0d pulses at cnt %0d want 1 at 60", done_cnt, done_at); end
    endtask

    task automatic test_beq();
        do_reset();
        branch_op = 1'b1; cond_branch = 1'b1; alu_cmp = 1'b1;
        fetch();
        measure(1'b0);
        vecs++;
        if (len != 32 || pc_cnt != 0) begin errs++; $display("FAIL beq_init_run got len=%0d pc=%0d want 32/0", len, pc_cnt); end
        vecs++;
        if ({jump32, wreq32, rreq32} !== 3'b110) begin errs++; $display("FAIL beq_wait2 got jump=%b wreq=%b rreq=%b want 1/1/0", jump32, wreq32, rreq32); end
        @(negedge clk); rf_ready = 1'b1;
        measure(1'b0);
        vecs++;
        if (len != 32 || pc_cnt != 32) begin errs++; $display("FAIL beq_second_run got len=%0d pc=%0d want 32/32", len, pc_cnt); end
        vecs++;
        if ({ibus32, jump32} !== 2'b10) begin errs++; $display("FAIL beq_end got ibus=%b jump=%b want 1/0", ibus32, jump32); end
    endtask

    task automatic test_load_misalign();
        do_reset();
        mem_op = 1'b1; mem_misalign = 1'b1; rd_op = 1'b1;
        fetch();
        measure(1'b0);
        vecs++;
        if ({dbus32, rreq32, wreq32, trap32} !== 4'b0101) begin
            errs++; $display("FAIL misalign_wait2 got dbus=%b rreq=%b wreq=%b trap=%b want 0/1/0/1", dbus32, rreq32, wreq32, trap32);
        end
        @(negedge clk); rf_ready = 1'b1;
        #1;
        vecs++;
        if (dbus32 !== 1'b0) begin errs++; $display("FAIL misalign_dbus got %b want 0", dbus32); end
        measure(1'b0);
        vecs++;
        if (len != 32 || trap_cnt != 32) begin errs++; $display("FAIL misalign_trap_run got len=%0d trap=%0d want 32/32", len, trap_cnt); end
        vecs++;
        if ({ibus32, trap32} !== 2'b10) begin errs++; $display("FAIL misalign_end got ibus=%b trap=%b want 1/0", ibus32, trap32); end
    endtask

    task automatic test_irq_fetch();
        do_reset();
        branch_op = 1'b1;
        @(negedge clk); ibus_ack = 1'b1; new_irq = 1'b1;
        #1;
        vecs++;
        if ({rreq32, init32} !== 2'b10) begin errs++; $display("FAIL irq_fetch got rreq=%b init=%b want 1/0", rreq32, init32); end
        @(negedge clk); ibus_ack = 1'b0; rf_ready = 1'b1;
        measure(1'b0);
        vecs++;
        if (len != 32 || pc_cnt != 32 || trap_cnt != 32) begin
            errs++; $display("FAIL irq_single_stage got len=%0d pc=%0d trap=%0d want 32/32/32", len, pc_cnt, trap_cnt);
        end
        vecs++;
        if (ibus32 !== 1'b1) begin errs++; $display("FAIL irq_refetch got %b want 1", ibus32); end
    endtask

    task automatic test_load_ack_reset();
        do_reset();
        mem_op = 1'b1; rd_op = 1'b1;
        fetch();
        measure(1'b0);
        vecs++;
        if ({dbus32, wreq32} !== 2'b10) begin errs++; $display("FAIL load_wait2 got dbus=%b wreq=%b want 1/0", dbus32, wreq32); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            vecs++;
            if ({dbus32, wreq32} !== 2'b10) begin errs++; $display("FAIL load_wait2_hold%0d got dbus=%b wreq=%b want 1/0", k, dbus32, wreq32); end
        end
        @(negedge clk); dbus_ack = 1'b1;
        #1;
        vecs++;
        if (wreq32 !== 1'b1) begin errs++; $display("FAIL load_ack_wreq got %b want 1", wreq32); end
        @(negedge clk); dbus_ack = 1'b0; rf_ready = 1'b1;
        @(negedge clk); rf_ready = 1'b0;
        #1;
        vecs++;
        if ({en32, init32} !== 2'b10) begin errs++; $display("FAIL load_second_run got en=%b init=%b want 1/0", en32, init32); end
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({cnt32, bc32, init32, en32, done32, pc32, jump32, trap32, ibus32, dbus32, mdv32, rreq32, wreq32, rd32} !== '0) begin
            errs++; $display("FAIL midrun_reset got cnt=%0d en=%b ibus=%b not all zero", cnt32, en32, ibus32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if ({ibus32, en32} !== 2'b10) begin errs++; $display("FAIL midrun_release got ibus=%b en=%b want 1/0", ibus32, en32); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_addi_w32();
        test_addi_w64();
        test_beq();
        test_load_misalign();
        test_irq_fetch();
        test_load_ack_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
